// File: rtl/fft_pkg.sv
// Shared types, default widths and a reference shift/round/clamp helper
// for the FFT output stage.
package fft_pkg;

  localparam int unsigned FFT_LOG2N   = 9;
  localparam int unsigned FFT_IN_W    = 33;
  localparam int unsigned FFT_OUT_W   = 16;
  localparam int unsigned FFT_NCH     = 2;
  localparam int unsigned FFT_SHIFT_W = 4;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } fft_state_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } sat_res_t;

  // Arithmetic shift, round-half-up by in_w-out_w bits, clamp to out_w signed.
  function automatic sat_res_t sat_round(input logic signed [63:0] x,
                                         input int unsigned sh,
                                         input int unsigned in_w,
                                         input int unsigned out_w);
    logic signed [63:0] s;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    int unsigned        d;
    sat_res_t           res;
    d       = in_w - out_w;
    s       = x >>> sh;
    r       = (s + (64'sd1 <<< (d - 1))) >>> d;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    res.val = r;
    res.sat = 1'b0;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_requant.sv
// One signed component: stage 1 shifts and rounds, stage 2 saturates.
// o_sat_c flags, from the stage-1 register, that the stage-2 clamp is active.
module fft_requant
  import fft_pkg::*;
#(
  parameter int unsigned IN_W    = FFT_IN_W,
  parameter int unsigned OUT_W   = FFT_OUT_W,
  parameter int unsigned SHIFT_W = FFT_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en1,
  input  logic               i_en2,
  input  logic [IN_W-1:0]    i_x,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [OUT_W-1:0]   o_y,
  output logic               o_sat_c
);

  localparam int unsigned D = IN_W - OUT_W;
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (D - 1);
  localparam logic signed [IN_W:0] MAXV = ((IN_W+1)'(1) << (OUT_W - 1)) - (IN_W+1)'(1);
  localparam logic signed [IN_W:0] MINV = -MAXV - (IN_W+1)'(1);

  logic signed [IN_W-1:0] w_s;
  logic signed [IN_W:0]   w_ext;
  logic signed [IN_W:0]   w_sum;
  logic signed [IN_W:0]   w_rnd;
  logic signed [IN_W:0]   r_rnd;
  logic [OUT_W-1:0]       w_y;

  // One extra bit keeps the rounding add from wrapping at the top of range.
  always_comb begin
    w_s   = $signed(i_x) >>> i_shift;
    w_ext = {w_s[IN_W-1], w_s};
    w_sum = w_ext + HALF;
    w_rnd = w_sum >>> D;
  end

  always_comb begin
    w_y     = r_rnd[OUT_W-1:0];
    o_sat_c = 1'b0;
    if (r_rnd > MAXV) begin
      w_y     = MAXV[OUT_W-1:0];
      o_sat_c = 1'b1;
    end else if (r_rnd < MINV) begin
      w_y     = MINV[OUT_W-1:0];
      o_sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rnd <= '0;
      o_y   <= '0;
    end else begin
      if (i_en1) r_rnd <= w_rnd;
      if (i_en2) o_y   <= w_y;
    end
  end

endmodule

// File: rtl/fft_out_stage.sv
// Post-FFT output stage: bin-index continuity FSM, per-component requantisation,
// frame markers, frame counter and per-channel frame saturation flags.
module fft_out_stage
  import fft_pkg::*;
#(
  parameter int unsigned NCH     = FFT_NCH,
  parameter int unsigned IN_W    = FFT_IN_W,
  parameter int unsigned OUT_W   = FFT_OUT_W,
  parameter int unsigned LOG2N   = FFT_LOG2N,
  parameter int unsigned SHIFT_W = FFT_SHIFT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic                 in_dv,
  input  logic [LOG2N-1:0]     in_index,
  input  logic [NCH*IN_W-1:0]  in_re,
  input  logic [NCH*IN_W-1:0]  in_im,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic [LOG2N-1:0]     out_index,
  output logic [NCH*OUT_W-1:0] out_re,
  output logic [NCH*OUT_W-1:0] out_im,
  output logic [15:0]          frame_cnt,
  output logic [NCH-1:0]       sat_frame,
  output logic                 sync_err
);

  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  fft_state_t         r_state, w_state_nxt;
  logic [LOG2N-1:0]   r_exp_idx, w_exp_nxt;
  logic [SHIFT_W-1:0] r_shift_q, w_shift_eff;
  logic               w_accept, w_err, w_sof, w_eof;
  logic               r_v1, r_sof1, r_eof1, r_err1;
  logic [LOG2N-1:0]   r_idx1;
  logic [NCH-1:0]     w_sat_re, w_sat_im, w_acc, r_sat_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= HUNT;
      r_exp_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_exp_idx <= w_exp_nxt;
    end
  end

  // A mismatching bin 0 resynchronises in place; any other mismatch drops to HUNT.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp_idx;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      HUNT: begin
        if (in_dv && in_index == '0) begin
          w_accept    = 1'b1;
          w_exp_nxt   = LOG2N'(1);
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (in_dv) begin
          if (in_index == r_exp_idx) begin
            w_accept  = 1'b1;
            w_exp_nxt = r_exp_idx + LOG2N'(1);
          end else begin
            w_err = 1'b1;
            if (in_index == '0) begin
              w_accept  = 1'b1;
              w_exp_nxt = LOG2N'(1);
            end else begin
              w_state_nxt = HUNT;
            end
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  assign w_sof       = w_accept && (in_index == '0);
  assign w_eof       = w_accept && (in_index == LAST_IDX);
  assign w_shift_eff = w_sof ? shift : r_shift_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_q <= '0;
      r_v1      <= 1'b0;
      r_sof1    <= 1'b0;
      r_eof1    <= 1'b0;
      r_err1    <= 1'b0;
      r_idx1    <= '0;
    end else begin
      if (w_sof) r_shift_q <= shift;
      r_v1   <= w_accept;
      r_sof1 <= w_sof;
      r_eof1 <= w_eof;
      r_err1 <= w_err;
      if (w_accept) r_idx1 <= in_index;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    fft_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_re (
      .clk(clk), .rst(rst), .i_en1(w_accept), .i_en2(r_v1),
      .i_x(in_re[k*IN_W +: IN_W]), .i_shift(w_shift_eff),
      .o_y(out_re[k*OUT_W +: OUT_W]), .o_sat_c(w_sat_re[k])
    );
    fft_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_im (
      .clk(clk), .rst(rst), .i_en1(w_accept), .i_en2(r_v1),
      .i_x(in_im[k*IN_W +: IN_W]), .i_shift(w_shift_eff),
      .o_y(out_im[k*OUT_W +: OUT_W]), .o_sat_c(w_sat_im[k])
    );
  end

  assign w_acc = (r_sof1 ? '0 : r_sat_acc) | w_sat_re | w_sat_im;

  // Output register stage; an aborted frame's saturation history is thrown away.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_index <= '0;
      sync_err  <= 1'b0;
      sat_frame <= '0;
      frame_cnt <= '0;
      r_sat_acc <= '0;
    end else begin
      out_valid <= r_v1;
      out_sof   <= r_v1 && r_sof1;
      out_eof   <= r_v1 && r_eof1;
      sync_err  <= r_err1;
      sat_frame <= '0;
      if (r_v1) begin
        out_index <= r_idx1;
        if (r_eof1) begin
          sat_frame <= w_acc;
          r_sat_acc <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          r_sat_acc <= w_acc;
        end
      end else if (r_err1) begin
        r_sat_acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_stage.sv
// Scoreboard bench for fft_out_stage: random and directed bins against an
// arithmetic reference of the index-tracking and requantisation rules.
module tb_fft_out_stage;

  localparam int NCH = 2, IN_W = 33, OUT_W = 16, LOG2N = 9, SHIFT_W = 4;
  localparam int NB = 1 << LOG2N;
  localparam int D  = IN_W - OUT_W;

  logic                 clk, rst;
  logic [SHIFT_W-1:0]   shift;
  logic                 in_dv;
  logic [LOG2N-1:0]     in_index;
  logic [NCH*IN_W-1:0]  in_re, in_im;
  logic                 out_valid, out_sof, out_eof, sync_err;
  logic [LOG2N-1:0]     out_index;
  logic [NCH*OUT_W-1:0] out_re, out_im;
  logic [15:0]          frame_cnt;
  logic [NCH-1:0]       sat_frame;

  fft_out_stage #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .LOG2N(LOG2N), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst(rst), .shift(shift), .in_dv(in_dv), .in_index(in_index),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .out_index(out_index), .out_re(out_re), .out_im(out_im),
    .frame_cnt(frame_cnt), .sat_frame(sat_frame), .sync_err(sync_err)
  );

  typedef struct packed {
    logic [31:0]          cyc;
    logic                 sof;
    logic                 eof;
    logic [LOG2N-1:0]     idx;
    logic [NCH*OUT_W-1:0] re;
    logic [NCH*OUT_W-1:0] im;
    logic [NCH-1:0]       sat;
    logic [15:0]          fcnt;
  } exp_t;

  exp_t   sq[$];
  int     eq[$];
  int     cyc = 0;
  int     zchk = -1;
  int     n_total = 0;
  int     n_bad = 0;
  longint xr[NCH];
  longint xi[NCH];

  bit             m_sync = 0;
  int             m_exp = 0;
  int             m_shq = 0;
  logic [NCH-1:0] m_acc = '0;
  logic [15:0]    m_fcnt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endtask

  // Reference requantisation: floor((x/2^sh + 2^(D-1)) / 2^D), clamped to OUT_W.
  function automatic longint requant(input longint x, input int sh, output bit sat);
    longint s, r, hi, lo;
    s   = x >>> sh;
    r   = (s + (longint'(1) << (D - 1))) >>> D;
    hi  = (longint'(1) << (OUT_W - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
    if (r > hi) begin sat = 1'b1; r = hi; end
    else if (r < lo) begin sat = 1'b1; r = lo; end
    return r;
  endfunction

  function automatic longint rval(input int bits);
    longint v;
    v = longint'({$urandom(), $urandom()});
    return v >>> (64 - bits);
  endfunction

  task automatic rnd_fill(input int bits);
    for (int k = 0; k < NCH; k++) begin
      xr[k] = rval(bits);
      xi[k] = rval(bits);
    end
  endtask

  task automatic send(input bit dv, input int idx, input int sh);
    bit     acc, s;
    exp_t   e;
    longint v;
    int     c;
    @(posedge clk); #1;
    c        = cyc;
    in_dv    = dv;
    in_index = LOG2N'(idx);
    shift    = SHIFT_W'(sh);
    for (int k = 0; k < NCH; k++) begin
      in_re[k*IN_W +: IN_W] = IN_W'(xr[k]);
      in_im[k*IN_W +: IN_W] = IN_W'(xi[k]);
    end
    acc = 1'b0;
    if (dv) begin
      if (!m_sync) acc = (idx == 0);
      else if (idx == m_exp) acc = 1'b1;
      else begin
        eq.push_back(c + 2);
        if (idx == 0) acc = 1'b1;
        else m_sync = 1'b0;
      end
    end
    if (acc) begin
      if (idx == 0) begin
        m_shq  = sh;
        m_acc  = '0;
        m_sync = 1'b1;
      end
      m_exp = (idx + 1) % NB;
      e     = '0;
      e.cyc = 32'(c + 2);
      e.sof = (idx == 0);
      e.eof = (idx == NB - 1);
      e.idx = LOG2N'(idx);
      for (int k = 0; k < NCH; k++) begin
        v = requant(xr[k], m_shq, s);
        e.re[k*OUT_W +: OUT_W] = OUT_W'(v);
        m_acc[k] = m_acc[k] | s;
        v = requant(xi[k], m_shq, s);
        e.im[k*OUT_W +: OUT_W] = OUT_W'(v);
        m_acc[k] = m_acc[k] | s;
      end
      if (e.eof) begin
        e.sat  = m_acc;
        m_fcnt = m_fcnt + 16'd1;
      end
      e.fcnt = m_fcnt;
      sq.push_back(e);
    end
  endtask

  task automatic run_bins(input int first, input int last, input int sh,
                          input int bits, input bit gaps);
    for (int i = first; i <= last; i++) begin
      rnd_fill(bits);
      send(1'b1, i, sh);
      if (gaps) begin
        rnd_fill(bits);
        send(1'b0, int'($urandom_range(0, NB - 1)), sh);
      end
    end
  endtask

  // Anything due after the reset edge never leaves the pipeline.
  task automatic do_reset();
    exp_t tq[$];
    int   tc[$];
    int   c;
    @(posedge clk); #1;
    c     = cyc;
    rst   = 1'b1;
    in_dv = 1'b0;
    for (int i = 0; i < sq.size(); i++) if (int'(sq[i].cyc) <= c) tq.push_back(sq[i]);
    for (int i = 0; i < eq.size(); i++) if (eq[i] <= c) tc.push_back(eq[i]);
    sq     = tq;
    eq     = tc;
    zchk   = c + 1;
    m_sync = 1'b0;
    m_acc  = '0;
    m_fcnt = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   ec;
    if (cyc == zchk) begin
      chk("rst_valid", 64'(out_valid), 0);
      chk("rst_sof_eof", 64'({out_sof, out_eof}), 0);
      chk("rst_index", 64'(out_index), 0);
      chk("rst_re", 64'(out_re), 0);
      chk("rst_im", 64'(out_im), 0);
      chk("rst_frame_cnt", 64'(frame_cnt), 0);
      chk("rst_sat_err", 64'({sat_frame, sync_err}), 0);
    end
    if (out_valid) begin
      if (sq.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_valid @cyc %0d: index %0d with empty scoreboard", cyc, out_index);
      end else begin
        e = sq.pop_front();
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("sof", 64'(out_sof), 64'(e.sof));
        chk("eof", 64'(out_eof), 64'(e.eof));
        chk("index", 64'(out_index), 64'(e.idx));
        chk("re", 64'(out_re), 64'(e.re));
        chk("im", 64'(out_im), 64'(e.im));
        chk("sat_frame", 64'(sat_frame), 64'(e.sat));
        chk("frame_cnt", 64'(frame_cnt), 64'(e.fcnt));
      end
    end
    if (sync_err) begin
      if (eq.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_sync_err @cyc %0d", cyc);
      end else begin
        ec = eq.pop_front();
        chk("sync_err_cyc", 64'(cyc), 64'(ec));
      end
    end
  end

  initial begin
    longint rv[4];
    rst = 1'b1; in_dv = 1'b0; in_index = '0; shift = '0; in_re = '0; in_im = '0;
    rv[0] = 65536; rv[1] = 65535; rv[2] = -65536; rv[3] = -65537;
    for (int k = 0; k < NCH; k++) begin xr[k] = 0; xi[k] = 0; end
    do_reset();

    // Rounding corners, then +max saturating on ch0 and -2^32 exact on ch1.
    rnd_fill(31); send(1'b1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NCH; k++) begin xr[k] = rv[i]; xi[k] = rv[3 - i]; end
      send(1'b1, i + 1, 0);
    end
    xr[0] = (longint'(1) << 32) - 1; xi[0] = 0;
    xr[1] = -(longint'(1) << 32);    xi[1] = -(longint'(1) << 32);
    send(1'b1, 5, 0);
    run_bins(6, NB - 1, 0, 31, 1'b0);

    // +max with shift 1 stays in range.
    rnd_fill(20); send(1'b1, 0, 1);
    for (int k = 0; k < NCH; k++) begin xr[k] = (longint'(1) << 32) - 1; xi[k] = xr[k]; end
    send(1'b1, 1, 1);
    run_bins(2, NB - 1, 1, 20, 1'b0);

    // Three back-to-back frames of full-range data.
    for (int f = 0; f < 3; f++) run_bins(0, NB - 1, int'($urandom_range(0, 15)), 33, 1'b0);

    // Jump to 150: error, drop until bin 0.
    run_bins(0, 99, 2, 33, 1'b0);
    rnd_fill(33); send(1'b1, 150, 2);
    run_bins(151, 160, 2, 33, 1'b0);
    run_bins(0, NB - 1, 3, 33, 1'b0);

    // Early bin 0: error plus immediate restart.
    run_bins(0, 99, 4, 33, 1'b0);
    run_bins(0, NB - 1, 5, 33, 1'b0);

    // Gapped frame with shift changed mid-frame, then a frame that picks it up.
    run_bins(0, 199, 3, 33, 1'b1);
    run_bins(200, NB - 1, 7, 33, 1'b1);
    run_bins(0, NB - 1, 7, 33, 1'b0);

    // Reset mid-frame; the tail is dropped and counting restarts.
    run_bins(0, 300, 6, 33, 1'b0);
    do_reset();
    run_bins(301, NB - 1, 6, 33, 1'b0);
    run_bins(0, NB - 1, 6, 33, 1'b0);

    for (int i = 0; i < 6; i++) send(1'b0, 0, 0);
    chk("scoreboard_drained", 64'(sq.size()), 0);
    chk("sync_err_drained", 64'(eq.size()), 0);
    chk("frame_cnt_final", 64'(frame_cnt), 64'(m_fcnt));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
